// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the two CGRA register-file write ports between NREQ requesters.
// Grants up to two writes per cycle to distinct addresses and drives the ports from registers.
module regfile_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int log2regs = 3,
  parameter int size     = 32
) (
  input  logic                     CGRA_Clock,
  input  logic                     CGRA_Reset,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*log2regs-1:0] req_addr,
  input  logic [NREQ*size-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     WE0,
  output logic [log2regs-1:0]      address_in0,
  output logic [size-1:0]          in0,
  output logic                     WE1,
  output logic [log2regs-1:0]      address_in1,
  output logic [size-1:0]          in1,
  output logic [15:0]              write_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]       rr_ptr_r;
  logic [PW-1:0]       scan_idx_s;
  logic [PW-1:0]       s0_idx_s;
  logic [PW-1:0]       s1_idx_s;
  logic [PW-1:0]       next_ptr_s;
  logic                s0_hit_s;
  logic                s1_hit_s;
  logic                take0_s;
  logic                take1_s;
  logic                grant0_s;
  logic                grant1_s;
  logic [log2regs-1:0] scan_addr_s;
  logic [log2regs-1:0] s0_addr_s;
  logic [log2regs-1:0] s1_addr_s;
  logic [size-1:0]     s0_data_s;
  logic [size-1:0]     s1_data_s;
  logic [16:0]         count_sum_s;

  // Scan requesters from rr_ptr onward; slot 1 skips anyone aiming at slot 0's register.
  always_comb begin
    s0_hit_s    = 1'b0;
    s1_hit_s    = 1'b0;
    s0_idx_s    = '0;
    s1_idx_s    = '0;
    s0_addr_s   = '0;
    scan_idx_s  = '0;
    scan_addr_s = '0;
    take0_s     = 1'b0;
    take1_s     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx_s  = rr_ptr_r + PW'(k);
      scan_addr_s = req_addr[int'(scan_idx_s)*log2regs +: log2regs];
      take0_s     = req_valid[scan_idx_s] && !s0_hit_s;
      take1_s     = req_valid[scan_idx_s] && s0_hit_s && !s1_hit_s &&
                    (scan_addr_s != s0_addr_s);
      if (take0_s) begin
        s0_hit_s  = 1'b1;
        s0_idx_s  = scan_idx_s;
        s0_addr_s = scan_addr_s;
      end else if (take1_s) begin
        s1_hit_s = 1'b1;
        s1_idx_s = scan_idx_s;
      end else begin
        s1_hit_s = s1_hit_s;
      end
    end
  end

  assign s1_addr_s = req_addr[int'(s1_idx_s)*log2regs +: log2regs];
  assign s0_data_s = req_data[int'(s0_idx_s)*size +: size];
  assign s1_data_s = req_data[int'(s1_idx_s)*size +: size];

  // Grants are suppressed while disabled or while reset is held, so ready drops immediately.
  always_comb begin
    grant0_s  = s0_hit_s && enable && CGRA_Reset;
    grant1_s  = s1_hit_s && grant0_s;
    req_ready = '0;
    if (grant0_s) begin
      req_ready[s0_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
    if (grant1_s) begin
      req_ready[s1_idx_s] = 1'b1;
    end else begin
      req_ready = req_ready;
    end
  end

  // Pointer moves just past the last requester granted this cycle.
  always_comb begin
    next_ptr_s = rr_ptr_r;
    if (grant1_s) begin
      next_ptr_s = s1_idx_s + PTR_ONE;
    end else if (grant0_s) begin
      next_ptr_s = s0_idx_s + PTR_ONE;
    end else begin
      next_ptr_s = rr_ptr_r;
    end
  end

  assign count_sum_s = {1'b0, write_count} + {16'd0, WE0} + {16'd0, WE1};

  // Port registers, round-robin pointer and saturating write counter.
  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
    if (!CGRA_Reset) begin
      WE0         <= 1'b0;
      WE1         <= 1'b0;
      address_in0 <= '0;
      address_in1 <= '0;
      in0         <= '0;
      in1         <= '0;
      rr_ptr_r    <= '0;
      write_count <= 16'd0;
    end else begin
      WE0 <= grant0_s;
      WE1 <= grant1_s;
      if (grant0_s) begin
        address_in0 <= s0_addr_s;
        in0         <= s0_data_s;
      end
      if (grant1_s) begin
        address_in1 <= s1_addr_s;
        in1         <= s1_data_s;
      end
      rr_ptr_r    <= next_ptr_s;
      write_count <= count_sum_s[16] ? 16'hFFFF : count_sum_s[15:0];
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: the driver pushes expected port writes into a
// scoreboard queue and a negedge monitor pops and compares whenever the write ports are active.
module tb_regfile_write_arbiter;

  logic              CGRA_Clock;
  logic              CGRA_Reset;
  logic              enable;
  logic [3:0]        req_valid;
  logic [3:0][2:0]   addr_tb;
  logic [3:0][31:0]  data_tb;
  logic [11:0]       req_addr;
  logic [127:0]      req_data;
  logic [3:0]        req_ready;
  logic              WE0;
  logic [2:0]        address_in0;
  logic [31:0]       in0;
  logic              WE1;
  logic [2:0]        address_in1;
  logic [31:0]       in1;
  logic [15:0]       write_count;

  typedef struct packed {
    logic        we1;
    logic [2:0]  a0;
    logic [31:0] d0;
    logic [2:0]  a1;
    logic [31:0] d1;
  } exp_t;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;

  assign req_addr = addr_tb;
  assign req_data = data_tb;

  regfile_write_arbiter #(.NREQ(4), .log2regs(3), .size(32)) dut (
    .CGRA_Clock (CGRA_Clock),
    .CGRA_Reset (CGRA_Reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .WE0        (WE0),
    .address_in0(address_in0),
    .in0        (in0),
    .WE1        (WE1),
    .address_in1(address_in1),
    .in1        (in1),
    .write_count(write_count)
  );

  initial begin
    CGRA_Clock = 1'b0;
    forever #5 CGRA_Clock = ~CGRA_Clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive, check ready, queue the expected write, advance to next negedge.
  task automatic step(input logic e, input logic [3:0] v, input logic [3:0] exp_rdy,
                      input int s0, input int s1);
    exp_t x;
    enable    = e;
    req_valid = v;
    #1;
    chk("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
    if (s0 >= 0) begin
      x.we1 = (s1 >= 0);
      x.a0  = addr_tb[s0];
      x.d0  = data_tb[s0];
      x.a1  = (s1 >= 0) ? addr_tb[s1] : 3'd0;
      x.d1  = (s1 >= 0) ? data_tb[s1] : 32'd0;
      sb_q.push_back(x);
    end
    @(negedge CGRA_Clock);
  endtask

  task automatic do_reset();
    CGRA_Reset = 1'b0;
    #1;
    chk("rst_WE0", {63'd0, WE0}, 64'd0);
    chk("rst_WE1", {63'd0, WE1}, 64'd0);
    chk("rst_addr0", {61'd0, address_in0}, 64'd0);
    chk("rst_in1", {32'd0, in1}, 64'd0);
    chk("rst_count", {48'd0, write_count}, 64'd0);
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    @(negedge CGRA_Clock);
    CGRA_Reset = 1'b1;
  endtask

  // Monitor: every negedge with an active write port must match the oldest expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge CGRA_Clock);
      if (WE1 && !WE0) chk("we1_without_we0", {62'd0, WE0, WE1}, 64'd2);
      if (WE0) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr0 %0d data0 %0h, expected no write",
                   address_in0, in0);
        end else begin
          e = sb_q.pop_front();
          chk("WE1", {63'd0, WE1}, {63'd0, e.we1});
          chk("address_in0", {61'd0, address_in0}, {61'd0, e.a0});
          chk("in0", {32'd0, in0}, {32'd0, e.d0});
          if (e.we1) begin
            chk("address_in1", {61'd0, address_in1}, {61'd0, e.a1});
            chk("in1", {32'd0, in1}, {32'd0, e.d1});
            chk("addr_distinct", {63'd0, address_in0 != address_in1}, 64'd1);
          end
        end
      end else if (sb_q.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_write: got WE0 0, expected write to addr %0d", sb_q[0].a0);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    CGRA_Reset  = 1'b0;
    enable      = 1'b1;
    req_valid   = 4'b1111;
    addr_tb     = '0;
    data_tb     = '0;
    @(negedge CGRA_Clock);
    do_reset();
    req_valid = 4'b0000;

    // Single requester
    addr_tb[2] = 3'd5;
    data_tb[2] = 32'hDEADBEEF;
    step(1'b1, 4'b0100, 4'b0100, 2, -1);
    step(1'b1, 4'b0000, 4'b0000, -1, -1);
    chk("count_single", {48'd0, write_count}, 64'd1);

    // All four requesters, distinct addresses, from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      addr_tb[i] = 3'(i + 1);
      data_tb[i] = 32'hA5A50000 + 32'(i * 17);
    end
    step(1'b1, 4'b1111, 4'b0011, 0, 1);
    step(1'b1, 4'b1111, 4'b1100, 2, 3);
    step(1'b1, 4'b1111, 4'b0011, 0, 1);
    step(1'b1, 4'b0000, 4'b0000, -1, -1);
    chk("count_six", {48'd0, write_count}, 64'd6);

    // Address conflict: req 1 shares req 0's register and must wait
    do_reset();
    addr_tb[0] = 3'd3; addr_tb[1] = 3'd3; addr_tb[2] = 3'd6; addr_tb[3] = 3'd7;
    data_tb[0] = 32'h00000100; data_tb[1] = 32'h00000101;
    data_tb[2] = 32'h00000102; data_tb[3] = 32'h00000103;
    step(1'b1, 4'b0111, 4'b0101, 0, 2);
    step(1'b1, 4'b0010, 4'b0010, 1, -1);
    step(1'b1, 4'b0000, 4'b0000, -1, -1);

    // Enable low holds the pointer (rr_ptr is 2 here)
    for (int i = 0; i < 4; i++) begin
      addr_tb[i] = 3'(i + 1);
      data_tb[i] = 32'hC0DE0000 + 32'(i);
    end
    step(1'b1, 4'b1111, 4'b1100, 2, 3);
    step(1'b0, 4'b1111, 4'b0000, -1, -1);
    chk("dis_WE0", {63'd0, WE0}, 64'd0);
    chk("dis_WE1", {63'd0, WE1}, 64'd0);
    step(1'b0, 4'b1111, 4'b0000, -1, -1);
    step(1'b1, 4'b1111, 4'b0011, 0, 1);
    step(1'b1, 4'b0000, 4'b0000, -1, -1);

    // Asynchronous reset right after a grant edge (rr_ptr is 2 here)
    step(1'b1, 4'b1111, 4'b1100, 2, 3);
    #2;
    CGRA_Reset = 1'b0;
    #1;
    chk("arst_WE0", {63'd0, WE0}, 64'd0);
    chk("arst_WE1", {63'd0, WE1}, 64'd0);
    chk("arst_count", {48'd0, write_count}, 64'd0);
    chk("arst_ready", {60'd0, req_ready}, 64'd0);
    @(negedge CGRA_Clock);
    CGRA_Reset = 1'b1;
    step(1'b1, 4'b1111, 4'b0011, 0, 1);
    step(1'b1, 4'b0000, 4'b0000, -1, -1);

    // Saturation: continuous dual writes drive the counter to 0xFFFE, then it must stick at 0xFFFF
    do_reset();
    for (int i = 0; i < 32768; i++) begin
      if (i % 2 == 0) step(1'b1, 4'b1111, 4'b0011, 0, 1);
      else            step(1'b1, 4'b1111, 4'b1100, 2, 3);
    end
    chk("count_fffe", {48'd0, write_count}, 64'h0000_0000_0000_FFFE);
    step(1'b1, 4'b1111, 4'b0011, 0, 1);
    chk("count_sat1", {48'd0, write_count}, 64'h0000_0000_0000_FFFF);
    step(1'b1, 4'b1111, 4'b1100, 2, 3);
    chk("count_sat2", {48'd0, write_count}, 64'h0000_0000_0000_FFFF);
    step(1'b1, 4'b0000, 4'b0000, -1, -1);
    step(1'b1, 4'b0000, 4'b0000, -1, -1);
    chk("count_sat3", {48'd0, write_count}, 64'h0000_0000_0000_FFFF);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
